// File: rtl/gpout_arbiter.sv
// Round-robin arbiter sharing the GPO write channel among NUM_REQ requesters.
// Define GPOUT_ARBITER_BITMASK_EN to add per-requester bit masks (i_req_mask).
module gpout_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_bits,
`ifdef GPOUT_ARBITER_BITMASK_EN
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_mask,
`endif
    output logic                       o_gpo_valid,
    input  logic                       i_gpo_ready,
    output logic [WIDTH-1:0]           o_gpo_bits,
    output logic [ID_W-1:0]            o_gpo_id,
    output logic [WIDTH-1:0]           o_last_value
);

    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             free;
    logic             grant;
    logic [WIDTH-1:0] sel_bits;
    logic [WIDTH-1:0] merged;

    assign free  = !o_gpo_valid || i_gpo_ready;
    // Reset gates the grant so no requester sees a handshake that would be lost.
    assign grant = free && found && !i_rst;

    // Scan starting at r_ptr; the first valid requester wins.
    always_comb begin
        cand   = '0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(r_ptr) + i) % NUM_REQ);
            if (!found && i_req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (grant) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign sel_bits = i_req_bits[winner*WIDTH +: WIDTH];

`ifdef GPOUT_ARBITER_BITMASK_EN
    logic [WIDTH-1:0] sel_mask;
    assign sel_mask = i_req_mask[winner*WIDTH +: WIDTH];
    // Only owned bits change; the rest come from the previously accepted value.
    assign merged   = (o_last_value & ~sel_mask) | (sel_bits & sel_mask);
`else
    assign merged   = sel_bits;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_gpo_valid  <= 1'b0;
            o_gpo_bits   <= '0;
            o_gpo_id     <= '0;
            o_last_value <= '0;
            r_ptr        <= '0;
        end else if (grant) begin
            o_gpo_valid  <= 1'b1;
            o_gpo_bits   <= merged;
            o_gpo_id     <= winner;
            o_last_value <= merged;
            r_ptr        <= ptr_next;
        end else if (i_gpo_ready) begin
            o_gpo_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpout_arbiter.sv
// Directed, table-driven bench for gpout_arbiter with NUM_REQ=4, WIDTH=8.
module tb_gpout_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_bits;
`ifdef GPOUT_ARBITER_BITMASK_EN
    logic [31:0] req_mask;
`endif
    logic        gpo_valid;
    logic        gpo_ready;
    logic [7:0]  gpo_bits;
    logic [1:0]  gpo_id;
    logic [7:0]  last_value;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpout_arbiter #(
        .NUM_REQ(4),
        .WIDTH  (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_bits  (req_bits),
`ifdef GPOUT_ARBITER_BITMASK_EN
        .i_req_mask  (req_mask),
`endif
        .o_gpo_valid (gpo_valid),
        .i_gpo_ready (gpo_ready),
        .o_gpo_bits  (gpo_bits),
        .o_gpo_id    (gpo_id),
        .o_last_value(last_value)
    );

    typedef struct {
        logic [3:0]  rv;
        logic [31:0] bits;
        logic        gr;
        logic [3:0]  rdy;
        logic        gv;
        logic [7:0]  gb;
        logic [1:0]  gid;
        logic [7:0]  last;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] BA = 32'h13121110;
    localparam logic [31:0] BB = 32'h13A51110;

    initial begin
        // Inputs, then expected values sampled before the edge.
        vecs[0]  = '{4'hF, BA, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 8'h00};
        vecs[1]  = '{4'hF, BA, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 8'h10};
        vecs[2]  = '{4'hF, BA, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1, 8'h11};
        vecs[3]  = '{4'hF, BA, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd2, 8'h12};
        vecs[4]  = '{4'hF, BA, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3, 8'h13};
        vecs[5]  = '{4'h0, BA, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0, 8'h10};
        vecs[6]  = '{4'h0, BA, 1'b0, 4'b0000, 1'b0, 8'h10, 2'd0, 8'h10};
        vecs[7]  = '{4'h4, BB, 1'b0, 4'b0100, 1'b0, 8'h10, 2'd0, 8'h10};
        vecs[8]  = '{4'hB, BB, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2, 8'hA5};
        vecs[9]  = '{4'hB, BB, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2, 8'hA5};
        vecs[10] = '{4'hB, BB, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2, 8'hA5};
        vecs[11] = '{4'hB, BB, 1'b1, 4'b1000, 1'b1, 8'hA5, 2'd2, 8'hA5};
        vecs[12] = '{4'h3, BB, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3, 8'h13};
        vecs[13] = '{4'h4, BB, 1'b1, 4'b0100, 1'b1, 8'h10, 2'd0, 8'h10};
        vecs[14] = '{4'h2, BB, 1'b1, 4'b0010, 1'b1, 8'hA5, 2'd2, 8'hA5};
        vecs[15] = '{4'h1, BB, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd1, 8'h11};
        vecs[16] = '{4'h3, BB, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 8'h10};
        vecs[17] = '{4'h0, BB, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd1, 8'h11};
        vecs[18] = '{4'h0, BB, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd1, 8'h11};

        rst       = 1'b1;
        req_valid = 4'hF;
        req_bits  = BA;
        gpo_ready = 1'b1;
`ifdef GPOUT_ARBITER_BITMASK_EN
        req_mask  = 32'hFFFFFFFF;
`endif

        // Reset held with every requester asking.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_valid", 32'(gpo_valid), 32'h0);
            chk("rst_last", 32'(last_value), 32'h0);
        end
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            req_valid = vecs[i].rv;
            req_bits  = vecs[i].bits;
            gpo_ready = vecs[i].gr;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_gvalid", i), 32'(gpo_valid), 32'(vecs[i].gv));
            chk($sformatf("v%0d_gbits", i), 32'(gpo_bits), 32'(vecs[i].gb));
            chk($sformatf("v%0d_gid", i), 32'(gpo_id), 32'(vecs[i].gid));
            chk($sformatf("v%0d_last", i), 32'(last_value), 32'(vecs[i].last));
            next_cycle();
        end

        // Reset while a write is stalled: it must be dropped and r_ptr cleared.
        req_valid = 4'h1;
        req_bits  = BA;
        gpo_ready = 1'b0;
        @(negedge clk);
        chk("mid_grant", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = 4'h0;
        rst       = 1'b1;
        @(negedge clk);
        chk("mid_pending", 32'(gpo_valid), 32'h1);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_dropped", 32'(gpo_valid), 32'h0);
        chk("mid_bits", 32'(gpo_bits), 32'h0);
        chk("mid_last", 32'(last_value), 32'h0);
        req_valid = 4'hF;
        gpo_ready = 1'b1;
        #1;
        chk("mid_ptr0", 32'(req_ready), 32'h1);
        next_cycle();

`ifdef GPOUT_ARBITER_BITMASK_EN
        rst       = 1'b1;
        req_valid = 4'h0;
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'h1;
        req_bits  = 32'h0000000F;
        req_mask  = 32'h000000FF;
        next_cycle();
        req_bits  = 32'h000000FF;
        req_mask  = 32'h000000F0;
        @(negedge clk);
        chk("mask_last0F", 32'(last_value), 32'h0F);
        chk("mask_grant0", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = 4'h2;
        req_bits  = 32'h00000000;
        req_mask  = 32'h00000100;
        @(negedge clk);
        chk("mask_ff", 32'(gpo_bits), 32'hFF);
        chk("mask_grant1", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = 4'h0;
        @(negedge clk);
        chk("mask_fe", 32'(gpo_bits), 32'hFE);
        chk("mask_last_fe", 32'(last_value), 32'hFE);
        next_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
